// File: rtl/input_checker.sv
// Player-input checker for the Simon Says game.
// Debounces button presses, echoes each accepted press on the LEDs, and
// compares it against the expected LED read from sequence memory at count_o.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for on_off_i with a legal level
// WAIT_PRESS   | waiting for exactly one button, timeout running
// DEBOUNCE     | candidate press must stay stable, timeout running
// WAIT_RELEASE | press accepted and echoed; waiting for a stable release
// CHECK        | one cycle: compare latched index with expected LED
// PASS         | whole sequence matched; held until on_off_i drops
// FAIL         | wrong button or timeout; held until on_off_i drops
module input_checker #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned TIMEOUT_CYC  = 250_000_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       on_off_i,
  input  logic [3:0] level_i,
  input  logic [3:0] buttons_i,
  input  logic [1:0] expected_led_i,
  output logic [3:0] count_o,
  output logic       done_o,
  output logic       pass_o,
  output logic       fail_o,
  output logic [9:0] led_out_o
);

  typedef enum logic [2:0] {
    IDLE, WAIT_PRESS, DEBOUNCE, WAIT_RELEASE, CHECK, PASS, FAIL
  } state_t;

  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYC - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  lvl_q, lvl_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] deb_q, deb_d;
  logic [31:0] tmo_q, tmo_d;
  logic [9:0]  led_q, led_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;

  logic       btn_onehot;
  logic [1:0] btn_idx;
  logic [3:0] idx_oh;

  // Decode the raw buttons: exactly-one-pressed flag and its index.
  always_comb begin
    btn_onehot = (buttons_i != 4'd0) && ((buttons_i & (buttons_i - 4'd1)) == 4'd0);
    btn_idx    = 2'd0;
    case (buttons_i)
      4'b0010: btn_idx = 2'd1;
      4'b0100: btn_idx = 2'd2;
      4'b1000: btn_idx = 2'd3;
      default: btn_idx = 2'd0;
    endcase
    idx_oh = 4'b0001 << idx_q;
  end

  // Next-state and output logic; on_off_i low clears everything.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    count_d = count_q;
    idx_d   = idx_q;
    deb_d   = deb_q;
    tmo_d   = tmo_q;
    led_d   = led_q;
    done_d  = (state_q == PASS) || (state_q == FAIL);
    pass_d  = (state_q == PASS);
    fail_d  = (state_q == FAIL);

    if (!on_off_i) begin
      state_d = IDLE;
      lvl_d   = 4'd0;
      count_d = 4'd0;
      idx_d   = 2'd0;
      deb_d   = 32'd0;
      tmo_d   = 32'd0;
      led_d   = 10'd0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_i <= 4'd10) begin
            lvl_d   = level_i;
            count_d = 4'd0;
            tmo_d   = 32'd0;
            deb_d   = 32'd0;
            state_d = (level_i == 4'd0) ? PASS : WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (tmo_q == TMO_LAST) begin
            state_d = FAIL;
          end else begin
            tmo_d = tmo_q + 32'd1;
            if (btn_onehot) begin
              idx_d   = btn_idx;
              deb_d   = 32'd0;
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (tmo_q == TMO_LAST) begin
            state_d = FAIL;
          end else begin
            tmo_d = tmo_q + 32'd1;
            if (buttons_i != idx_oh) begin
              idx_d   = 2'd0;
              deb_d   = 32'd0;
              state_d = WAIT_PRESS;
            end else if (deb_q == DEB_LAST) begin
              led_d   = {6'd0, idx_oh};
              deb_d   = 32'd0;
              state_d = WAIT_RELEASE;
            end else begin
              deb_d = deb_q + 32'd1;
            end
          end
        end
        WAIT_RELEASE: begin
          if (buttons_i != 4'd0) begin
            deb_d = 32'd0;
          end else if (deb_q == DEB_LAST) begin
            deb_d   = 32'd0;
            state_d = CHECK;
          end else begin
            deb_d = deb_q + 32'd1;
          end
        end
        CHECK: begin
          led_d = 10'd0;
          if (idx_q != expected_led_i) begin
            state_d = FAIL;
          end else if (count_q == lvl_q - 4'd1) begin
            state_d = PASS;
          end else begin
            count_d = count_q + 4'd1;
            tmo_d   = 32'd0;
            state_d = WAIT_PRESS;
          end
        end
        PASS:    state_d = PASS;
        FAIL:    state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      lvl_q   <= 4'd0;
      count_q <= 4'd0;
      idx_q   <= 2'd0;
      deb_q   <= 32'd0;
      tmo_q   <= 32'd0;
      led_q   <= 10'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      deb_q   <= deb_d;
      tmo_q   <= tmo_d;
      led_q   <= led_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign count_o   = count_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign fail_o    = fail_q;
  assign led_out_o = led_q;

endmodule
